// File: rtl/snake_body_tracker_pkg.sv
// rtl/snake_body_tracker_pkg.sv - shared grid sizes, direction codes, FSM states and cell types
package snake_body_tracker_pkg;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int MAX_LEN = 31;
    localparam int XW      = 5;
    localparam int YW      = 5;
    localparam int CW      = XW + YW;
    localparam int IW      = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DEAD = 2'd3
    } state_e;

    // A cell packs {x, y}; the segment history is a flat packed array of cells.
    typedef logic [CW-1:0]              cell_t;
    typedef logic [MAX_LEN-1:0][CW-1:0] seg_arr_t;

    localparam logic [XW-1:0] HOME_X = XW'(GRID_W / 2);
    localparam logic [YW-1:0] HOME_Y = YW'(GRID_H / 2);

    function automatic cell_t mk_cell(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// rtl/snake_body_tracker_if.sv - controller/keypad/renderer signal bundle for the snake tracker
interface snake_body_tracker_if;
    import snake_body_tracker_pkg::*;

    logic            gamePrepare;
    logic            gameStart;
    logic [IW-1:0]   size;
    logic            move_tick;
    logic [1:0]      dir_in;
    logic            dir_valid;
    logic [XW-1:0]   cherry_x;
    logic [YW-1:0]   cherry_y;
    logic [XW-1:0]   query_x;
    logic [YW-1:0]   query_y;
    logic [XW-1:0]   head_x;
    logic [YW-1:0]   head_y;
    logic            snakeEatCherry;
    logic            bump;
    logic            query_head;
    logic            query_body;

    modport master (
        output gamePrepare, gameStart, size, move_tick, dir_in, dir_valid,
               cherry_x, cherry_y, query_x, query_y,
        input  head_x, head_y, snakeEatCherry, bump, query_head, query_body
    );

    modport slave (
        input  gamePrepare, gameStart, size, move_tick, dir_in, dir_valid,
               cherry_x, cherry_y, query_x, query_y,
        output head_x, head_y, snakeEatCherry, bump, query_head, query_body
    );

endinterface

// File: rtl/snake_seg_match.sv
// rtl/snake_seg_match.sv - parallel compare of one cell against segment slots lo..hi
module snake_seg_match
    import snake_body_tracker_pkg::*;
(
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  seg_arr_t      seg_i,
    input  logic [IW-1:0] lo_i,
    input  logic [IW-1:0] hi_i,
    output logic          hit_o
);

    // An empty range (hi < lo) never hits.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (IW'(i) >= lo_i && IW'(i) <= hi_i && seg_i[i] == mk_cell(x_i, y_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body_tracker.sv
// rtl/snake_body_tracker.sv - snake head/body state, movement FSM, collisions and render query
module snake_body_tracker
    import snake_body_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    snake_body_tracker_if.slave  bus
);

    localparam logic [XW:0] X_MAX = (XW + 1)'(GRID_W - 1);
    localparam logic [YW:0] Y_MAX = (YW + 1)'(GRID_H - 1);
    localparam logic [XW:0] X_ONE = (XW + 1)'(1);
    localparam logic [YW:0] Y_ONE = (YW + 1)'(1);

    state_e   state_q;
    dir_e     dir_q;
    seg_arr_t seg_q;
    logic     eat_q, bump_q, qhead_q, qbody_q;

    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [XW:0]   nx_ext;
    logic [YW:0]   ny_ext;
    cell_t         nxt_d;
    logic          wall_hit, self_hit, qbody_hit;
    logic [IW-1:0] hi_self, hi_query;
    logic          go_idle, start_run;

    assign head_x = seg_q[0][CW-1:YW];
    assign head_y = seg_q[0][YW-1:0];

    // Candidate next head, one bit wider so a step off either edge shows as borrow/overflow.
    always_comb begin
        nx_ext = {1'b0, head_x};
        ny_ext = {1'b0, head_y};
        case (dir_q)
            DIR_UP:    ny_ext = {1'b0, head_y} - Y_ONE;
            DIR_RIGHT: nx_ext = {1'b0, head_x} + X_ONE;
            DIR_DOWN:  ny_ext = {1'b0, head_y} + Y_ONE;
            DIR_LEFT:  nx_ext = {1'b0, head_x} - X_ONE;
            default:   nx_ext = {1'b0, head_x};
        endcase
        wall_hit = nx_ext[XW] || ny_ext[YW] || (nx_ext > X_MAX) || (ny_ext > Y_MAX);
        nxt_d    = mk_cell(nx_ext[XW-1:0], ny_ext[YW-1:0]);
    end

    // Self check skips the tail slot size-1 since it vacates this step; body query covers 1..size-1.
    assign hi_self  = (bus.size >= IW'(2)) ? bus.size - IW'(2) : '0;
    assign hi_query = (bus.size >= IW'(1)) ? bus.size - IW'(1) : '0;

    snake_seg_match u_self_match (
        .x_i   (nx_ext[XW-1:0]),
        .y_i   (ny_ext[YW-1:0]),
        .seg_i (seg_q),
        .lo_i  (IW'(1)),
        .hi_i  (hi_self),
        .hit_o (self_hit)
    );

    snake_seg_match u_query_match (
        .x_i   (bus.query_x),
        .y_i   (bus.query_y),
        .seg_i (seg_q),
        .lo_i  (IW'(1)),
        .hi_i  (hi_query),
        .hit_o (qbody_hit)
    );

    // Every path into or through IDLE re-initialises, so IDLE cycles always show the home snake.
    assign go_idle   = !reset || bus.gamePrepare || state_q == S_IDLE
                       || (state_q == S_RUN && !bus.gameStart);
    assign start_run = reset && !bus.gamePrepare && state_q == S_IDLE && bus.gameStart;

    // Movement FSM with registered eat/bump/query outputs.
    always_ff @(posedge clk) begin
        if (go_idle) begin
            state_q <= start_run ? S_RUN : S_IDLE;
            seg_q   <= {MAX_LEN{mk_cell(HOME_X, HOME_Y)}};
            dir_q   <= DIR_RIGHT;
            eat_q   <= 1'b0;
            bump_q  <= 1'b0;
            qhead_q <= 1'b0;
            qbody_q <= 1'b0;
        end else begin
            qhead_q <= (mk_cell(bus.query_x, bus.query_y) == seg_q[0]);
            qbody_q <= qbody_hit;
            case (state_q)
                S_RUN: begin
                    eat_q <= 1'b0;
                    if (bus.dir_valid && bus.dir_in != (dir_q ^ 2'b10)) begin
                        dir_q <= dir_e'(bus.dir_in);
                    end
                    if (bus.move_tick) begin
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (wall_hit || self_hit) begin
                        bump_q  <= 1'b1;
                        state_q <= S_DEAD;
                    end else begin
                        seg_q   <= {seg_q[MAX_LEN-2:0], nxt_d};
                        eat_q   <= (nxt_d == mk_cell(bus.cherry_x, bus.cherry_y));
                        state_q <= S_RUN;
                    end
                end
                S_DEAD: begin
                    state_q <= S_DEAD;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.head_x         = head_x;
    assign bus.head_y         = head_y;
    assign bus.snakeEatCherry = eat_q;
    assign bus.bump           = bump_q;
    assign bus.query_head     = qhead_q;
    assign bus.query_body     = qbody_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// tb/tb_snake_body_tracker.sv - directed self-checking bench for snake_body_tracker
module tb_snake_body_tracker;
    import snake_body_tracker_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    int   eat_cnt = 0;

    always #5 clk = ~clk;

    snake_body_tracker_if bus();

    snake_body_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Count eat pulse cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.snakeEatCherry === 1'b1) eat_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_head(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(bus.head_x), 32'(x));
        check({tag, "_y"}, 32'(bus.head_y), 32'(y));
    endtask

    task automatic prepare_start(input int sz);
        @(negedge clk);
        bus.gamePrepare = 1'b1;
        bus.gameStart   = 1'b0;
        bus.size        = 5'(sz);
        @(negedge clk);
        bus.gamePrepare = 1'b0;
        bus.gameStart   = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.move_tick = 1'b1;
        @(negedge clk);
        bus.move_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk);
        bus.dir_in    = d;
        bus.dir_valid = 1'b1;
        @(negedge clk);
        bus.dir_valid = 1'b0;
    endtask

    task automatic query(input int x, input int y);
        @(negedge clk);
        bus.query_x = 5'(x);
        bus.query_y = 5'(y);
        @(negedge clk);
    endtask

    task automatic square();
        set_dir(DIR_UP);    tick();
        set_dir(DIR_LEFT);  tick();
        set_dir(DIR_DOWN);  tick();
        set_dir(DIR_RIGHT); tick();
    endtask

    initial begin
        reset           = 1'b0;
        bus.gamePrepare = 1'b0;
        bus.gameStart   = 1'b0;
        bus.size        = 5'd3;
        bus.move_tick   = 1'b0;
        bus.dir_in      = 2'b00;
        bus.dir_valid   = 1'b0;
        bus.cherry_x    = 5'd0;
        bus.cherry_y    = 5'd0;
        bus.query_x     = 5'd16;
        bus.query_y     = 5'd12;
        repeat (2) @(negedge clk);

        check_head("rst_head", 16, 12);
        check("rst_bump", 32'(bus.bump), 32'd0);
        check("rst_eat", 32'(bus.snakeEatCherry), 32'd0);
        check("rst_qhead", 32'(bus.query_head), 32'd0);
        check("rst_qbody", 32'(bus.query_body), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b1;

        // Straight run right, no cherry in the way.
        prepare_start(3);
        eat_cnt = 0;
        repeat (3) tick();
        check_head("run3", 19, 12);
        check("run3_bump", 32'(bus.bump), 32'd0);
        check("run3_noeat", 32'(eat_cnt), 32'd0);
        query(19, 12);
        check("q_head_on", 32'(bus.query_head), 32'd1);
        check("q_head_body", 32'(bus.query_body), 32'd0);
        query(17, 12);
        check("q_last_body", 32'(bus.query_body), 32'd1);
        query(16, 12);
        check("q_hidden_slot", 32'(bus.query_body), 32'd0);
        check("q_hidden_head", 32'(bus.query_head), 32'd0);

        // Cherry one cell ahead.
        bus.cherry_x = 5'd17;
        bus.cherry_y = 5'd12;
        prepare_start(3);
        eat_cnt = 0;
        tick();
        check("eat_pulse", 32'(bus.snakeEatCherry), 32'd1);
        check_head("eat_head", 17, 12);
        @(negedge clk);
        check("eat_drop", 32'(bus.snakeEatCherry), 32'd0);
        check("eat_once", 32'(eat_cnt), 32'd1);
        bus.cherry_x = 5'd0;
        bus.cherry_y = 5'd0;

        // Drive to the right wall at (31,5) and hit it.
        prepare_start(3);
        repeat (15) tick();
        check_head("wall_row", 31, 12);
        set_dir(DIR_UP);
        repeat (7) tick();
        check_head("wall_corner", 31, 5);
        check("wall_prebump", 32'(bus.bump), 32'd0);
        set_dir(DIR_RIGHT);
        tick();
        check("wall_bump", 32'(bus.bump), 32'd1);
        check_head("wall_hold", 31, 5);
        check("wall_dead", 32'(dut.state_q), 32'(S_DEAD));
        repeat (2) tick();
        check_head("dead_frozen", 31, 5);
        check("dead_bump", 32'(bus.bump), 32'd1);
        @(negedge clk);
        bus.gamePrepare = 1'b1;
        @(negedge clk);
        check_head("prep_head", 16, 12);
        check("prep_bump", 32'(bus.bump), 32'd0);
        check("prep_state", 32'(dut.state_q), 32'(S_IDLE));
        bus.gamePrepare = 1'b0;

        // Top wall: from (16,12) the borrow at y=0 must be caught.
        prepare_start(3);
        set_dir(DIR_UP);
        repeat (12) tick();
        check_head("top_edge", 16, 0);
        check("top_nobump", 32'(bus.bump), 32'd0);
        tick();
        check("top_bump", 32'(bus.bump), 32'd1);
        check_head("top_hold", 16, 0);

        // Square turn: size 5 bites its body, size 4 steps into the vacated tail.
        prepare_start(5);
        square();
        check("sq5_bump", 32'(bus.bump), 32'd1);
        check_head("sq5_head", 15, 12);
        prepare_start(4);
        square();
        check("sq4_bump", 32'(bus.bump), 32'd0);
        check_head("sq4_head", 16, 12);
        query(16, 11);
        check("sq4_q_tail", 32'(bus.query_body), 32'd1);
        bus.size = 5'd3;
        @(negedge clk);
        check("sq3_q_tail", 32'(bus.query_body), 32'd0);
        query(15, 12);
        check("sq3_q_neck", 32'(bus.query_body), 32'd1);

        // Reversal is ignored; the last valid request before the tick wins.
        prepare_start(3);
        set_dir(DIR_LEFT);
        tick();
        check_head("rev_ignored", 17, 12);
        @(negedge clk);
        bus.dir_in    = DIR_UP;
        bus.dir_valid = 1'b1;
        @(negedge clk);
        bus.dir_in    = DIR_RIGHT;
        @(negedge clk);
        bus.dir_valid = 1'b0;
        tick();
        check_head("last_req", 18, 12);

        // gamePrepare beats a simultaneous move_tick.
        @(negedge clk);
        bus.gamePrepare = 1'b1;
        bus.move_tick   = 1'b1;
        @(negedge clk);
        bus.gamePrepare = 1'b0;
        bus.move_tick   = 1'b0;
        check("prep_vs_tick", 32'(dut.state_q), 32'(S_IDLE));
        check_head("prep_vs_tick", 16, 12);

        // Reset in the middle of a run with a tick pending.
        prepare_start(3);
        tick();
        query(17, 12);
        @(negedge clk);
        reset         = 1'b0;
        bus.move_tick = 1'b1;
        @(negedge clk);
        check_head("mid_rst", 16, 12);
        check("mid_rst_bump", 32'(bus.bump), 32'd0);
        check("mid_rst_eat", 32'(bus.snakeEatCherry), 32'd0);
        check("mid_rst_qhead", 32'(bus.query_head), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset         = 1'b1;
        bus.move_tick = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
